median_win3x3_pipe: RTL and testbench

//   Streaming 3x3 median filter. Each accepted beat is one 3-pixel window column
//   (rows r-1, r, r+1 of one image column). The block keeps the last 3 sorted

---
 rtl/median_win3x3_pipe_pkg.sv | 24 ++
 rtl/median_win3x3_pipe_sort3.sv | 40 ++++
 rtl/median_win3x3_pipe.sv | 155 +++++++++++++++
 tb/tb_median_win3x3_pipe.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_win3x3_pipe_pkg.sv
// Shared definitions for the streaming 3x3 median filter.
//   - DATA_W_DEF : default pixel width (unsigned pixels)
//   - mode_e     : result selector encodings (2'b11 behaves as median)
//   - LO/MD/HI   : field indices of a sorted window column
//   - sat3_inc   : column counter increment saturating at 3
package median_win3x3_pipe_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    MODE_MED = 2'b00,
    MODE_MIN = 2'b01,
    MODE_MAX = 2'b10
  } mode_e;

  localparam int unsigned LO = 0;
  localparam int unsigned MD = 1;
  localparam int unsigned HI = 2;

  function automatic logic [1:0] sat3_inc(input logic [1:0] c);
    return (c == 2'd3) ? 2'd3 : c + 2'd1;
  endfunction

endpackage

// File: rtl/median_win3x3_pipe_sort3.sv
// Combinational 3-input sorter.
//   i_a, i_b, i_c : unsigned inputs
//   o_lo, o_md, o_hi : ascending order of the inputs
// Strict '<' compares, so equal inputs never swap and ties are deterministic.
module median_win3x3_pipe_sort3 #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_c,
  output logic [DATA_W-1:0] o_lo,
  output logic [DATA_W-1:0] o_md,
  output logic [DATA_W-1:0] o_hi
);

  logic [DATA_W-1:0] x_lo, x_hi, y_md;

  always_comb begin
    // order a/b, insert c against the larger, then settle the lower pair
    x_lo = i_a;
    x_hi = i_b;
    if (i_b < i_a) begin
      x_lo = i_b;
      x_hi = i_a;
    end
    y_md = x_hi;
    o_hi = i_c;
    if (i_c < x_hi) begin
      y_md = i_c;
      o_hi = x_hi;
    end
    o_lo = x_lo;
    o_md = y_md;
    if (y_md < x_lo) begin
      o_lo = y_md;
      o_md = x_lo;
    end
  end

endmodule

// File: rtl/median_win3x3_pipe.sv
// Streaming 3x3 median/min/max filter, 3 register stages.
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_in_valid / o_in_ready : column beat handshake
//   i_sol                   : start of line (beat is column 0)
//   i_mode                  : 00 median, 01 min, 10 max, 11 median
//   i_col                   : one window column, top row in the low bits
//   o_valid / i_out_ready   : result handshake, result held until accepted
//   o_data                  : filter result
// Stage A sorts each column and shifts the 3-column window, stage B reduces
// the sorted columns, stage C picks median (med of maxlo/medmd/minhi), min or max.
module median_win3x3_pipe
  import median_win3x3_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic              i_sol,
  input  logic [1:0]        i_mode,
  input  logic [3*DATA_W-1:0] i_col,
  output logic              o_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_data
);

  typedef logic [2:0][DATA_W-1:0] col_t;

  logic              en;
  col_t              in_sorted;
  col_t              w0_q, w1_q, w2_q, w0_d, w1_d, w2_d;
  logic [1:0]        cnt_q, cnt_d, mode_a_q, mode_a_d, mode_b_q, mode_b_d;
  logic              va_q, va_d, vb_q, vb_d, valid_q, valid_d;
  logic [DATA_W-1:0] maxlo_q, maxlo_d, medmd_q, medmd_d, minhi_q, minhi_d;
  logic [DATA_W-1:0] minall_q, minall_d, maxall_q, maxall_d, data_q, data_d;
  logic [DATA_W-1:0] los_lo, los_hi, mds_md, his_lo, his_hi, med9;
  logic [DATA_W-1:0] los_md_unused, mds_lo_unused, mds_hi_unused;
  logic [DATA_W-1:0] his_md_unused, med_lo_unused, med_hi_unused;

  assign en         = ~valid_q | i_out_ready;
  assign o_in_ready = en;
  assign o_valid    = valid_q;
  assign o_data     = data_q;

  median_win3x3_pipe_sort3 #(.DATA_W(DATA_W)) u_sort_col (
    .i_a(i_col[DATA_W-1:0]), .i_b(i_col[2*DATA_W-1:DATA_W]), .i_c(i_col[3*DATA_W-1:2*DATA_W]),
    .o_lo(in_sorted[LO]), .o_md(in_sorted[MD]), .o_hi(in_sorted[HI]));

  median_win3x3_pipe_sort3 #(.DATA_W(DATA_W)) u_sort_los (
    .i_a(w0_q[LO]), .i_b(w1_q[LO]), .i_c(w2_q[LO]),
    .o_lo(los_lo), .o_md(los_md_unused), .o_hi(los_hi));

  median_win3x3_pipe_sort3 #(.DATA_W(DATA_W)) u_sort_mds (
    .i_a(w0_q[MD]), .i_b(w1_q[MD]), .i_c(w2_q[MD]),
    .o_lo(mds_lo_unused), .o_md(mds_md), .o_hi(mds_hi_unused));

  median_win3x3_pipe_sort3 #(.DATA_W(DATA_W)) u_sort_his (
    .i_a(w0_q[HI]), .i_b(w1_q[HI]), .i_c(w2_q[HI]),
    .o_lo(his_lo), .o_md(his_md_unused), .o_hi(his_hi));

  median_win3x3_pipe_sort3 #(.DATA_W(DATA_W)) u_sort_med (
    .i_a(maxlo_q), .i_b(medmd_q), .i_c(minhi_q),
    .o_lo(med_lo_unused), .o_md(med9), .o_hi(med_hi_unused));

  always_comb begin
    w0_d     = w0_q;
    w1_d     = w1_q;
    w2_d     = w2_q;
    cnt_d    = cnt_q;
    va_d     = va_q;
    mode_a_d = mode_a_q;
    maxlo_d  = maxlo_q;
    medmd_d  = medmd_q;
    minhi_d  = minhi_q;
    minall_d = minall_q;
    maxall_d = maxall_q;
    vb_d     = vb_q;
    mode_b_d = mode_b_q;
    data_d   = data_q;
    valid_d  = valid_q;
    if (en) begin
      if (i_in_valid) begin
        w0_d     = w1_q;
        w1_d     = w2_q;
        w2_d     = in_sorted;
        cnt_d    = i_sol ? 2'd1 : sat3_inc(cnt_q);
        va_d     = (cnt_d == 2'd3);
        mode_a_d = i_mode;
      end else begin
        va_d = 1'b0;
      end
      maxlo_d  = los_hi;
      medmd_d  = mds_md;
      minhi_d  = his_lo;
      minall_d = los_lo;
      maxall_d = his_hi;
      vb_d     = va_q;
      mode_b_d = mode_a_q;
      if (mode_b_q == MODE_MIN)      data_d = minall_q;
      else if (mode_b_q == MODE_MAX) data_d = maxall_q;
      else                           data_d = med9;
      valid_d = vb_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      w0_q     <= '0;
      w1_q     <= '0;
      w2_q     <= '0;
      cnt_q    <= '0;
      va_q     <= 1'b0;
      mode_a_q <= '0;
    end else begin
      w0_q     <= w0_d;
      w1_q     <= w1_d;
      w2_q     <= w2_d;
      cnt_q    <= cnt_d;
      va_q     <= va_d;
      mode_a_q <= mode_a_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      maxlo_q  <= '0;
      medmd_q  <= '0;
      minhi_q  <= '0;
      minall_q <= '0;
      maxall_q <= '0;
      vb_q     <= 1'b0;
      mode_b_q <= '0;
    end else begin
      maxlo_q  <= maxlo_d;
      medmd_q  <= medmd_d;
      minhi_q  <= minhi_d;
      minall_q <= minall_d;
      maxall_q <= maxall_d;
      vb_q     <= vb_d;
      mode_b_q <= mode_b_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_median_win3x3_pipe.sv
// Directed bench for median_win3x3_pipe, 8-bit and 12-bit instances in lockstep.
// The 12-bit instance sees every pixel mapped by v -> v*16 + v/16, which is
// strictly increasing, so its expected result is the same mapping of the 8-bit one.
module tb_median_win3x3_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, sol, out_ready;
  logic [1:0]  mode;
  logic [23:0] col8;
  logic [35:0] col12;
  logic        o_in_ready, o_valid, in_ready12_unused, o_valid12;
  logic [7:0]  o_data;
  logic [11:0] o_data12;

  always #5 clk = ~clk;

  median_win3x3_pipe #(.DATA_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(o_in_ready),
    .i_sol(sol), .i_mode(mode), .i_col(col8), .o_valid(o_valid),
    .i_out_ready(out_ready), .o_data(o_data));

  median_win3x3_pipe #(.DATA_W(12)) dut12 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready12_unused),
    .i_sol(sol), .i_mode(mode), .i_col(col12), .o_valid(o_valid12),
    .i_out_ready(out_ready), .o_data(o_data12));

  int          total = 0;
  int          bad   = 0;
  int          tick_no = 0;
  int unsigned hist[3][3];
  int unsigned cnt_m = 0;
  int unsigned exp_q[$];
  int          due_q[$];
  int unsigned got_q[$];
  bit          last_v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned map12(input int unsigned v);
    return v * 16 + v / 16;
  endfunction

  function automatic int unsigned ref_out(input logic [1:0] m);
    int unsigned v[9];
    int unsigned tmp;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) v[i*3+j] = hist[i][j];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin
          tmp = v[j]; v[j] = v[j+1]; v[j+1] = tmp;
        end
    if (m == 2'b01) return v[0];
    if (m == 2'b10) return v[8];
    return v[4];
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    due_q.delete();
    cnt_m = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) hist[i][j] = 0;
  endfunction

  // One cycle: drive at negedge, sample 1ns later, check and update the model.
  task automatic tick(input bit v, input bit s, input logic [1:0] m,
                      input int unsigned t, input int unsigned mi, input int unsigned b,
                      input bit ordy, output bit acc);
    logic [7:0]  t8, m8, b8;
    logic [11:0] t12, m12, b12;
    @(negedge clk);
    t8 = t[7:0]; m8 = mi[7:0]; b8 = b[7:0];
    t12 = 12'(map12(t)); m12 = 12'(map12(mi)); b12 = 12'(map12(b));
    in_valid  = v;
    sol       = s;
    mode      = m;
    col8      = {b8, m8, t8};
    col12     = {b12, m12, t12};
    out_ready = ordy;
    #1;
    tick_no++;
    last_v = o_valid;
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", o_valid, 1'b0);
      end else begin
        check("data", o_data, exp_q[0]);
        check("data12", o_data12, map12(exp_q[0]));
        check("valid12", o_valid12, 1'b1);
        check("not_early", tick_no >= due_q[0], 1'b1);
        if (ordy) begin
          got_q.push_back(o_data);
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
      end
    end
    acc = v && o_in_ready;
    if (acc) begin
      hist[0] = hist[1];
      hist[1] = hist[2];
      hist[2] = '{t, mi, b};
      cnt_m = s ? 1 : ((cnt_m < 3) ? cnt_m + 1 : 3);
      if (cnt_m == 3) begin
        exp_q.push_back(ref_out(m));
        due_q.push_back(tick_no + 3);
      end
    end
  endtask

  task automatic push_beat(input bit s, input logic [1:0] m,
                           input int unsigned t, input int unsigned mi, input int unsigned b);
    bit acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) tick(1'b1, s, m, t, mi, b, 1'b1, acc);
    check("accept_timeout", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 2'b00, 0, 0, 0, 1'b1, acc);
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) idle(1);
    idle(3);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    bit acc;
    bit v1, v2, v3;
    int k, held;
    bit ordy;
    rst_n = 1'b0; in_valid = 1'b0; sol = 1'b0; mode = 2'b00;
    col8 = '0; col12 = '0; out_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", o_valid, 1'b0);
    check("rst_data", o_data, 8'd0);
    check("rst_in_ready", o_in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: basic median with latency
    got_q.delete();
    push_beat(1'b1, 2'b00, 1, 2, 3);
    push_beat(1'b0, 2'b00, 4, 5, 6);
    push_beat(1'b0, 2'b00, 7, 8, 9);
    idle(1); v1 = last_v;
    idle(1); v2 = last_v;
    idle(1); v3 = last_v;
    check("t1_lat1", v1, 1'b0);
    check("t1_lat2", v2, 1'b0);
    check("t1_lat3", v3, 1'b1);
    check("t1_count", got_q.size(), 1);
    if (got_q.size() > 0) check("t1_value", got_q[0], 5);
    drain();

    // 2: per-beat mode
    got_q.delete();
    push_beat(1'b1, 2'b00, 1, 2, 3);
    push_beat(1'b0, 2'b00, 4, 5, 6);
    push_beat(1'b0, 2'b00, 7, 8, 9);
    push_beat(1'b0, 2'b01, 9, 9, 9);
    push_beat(1'b0, 2'b10, 0, 0, 0);
    drain();
    check("t2_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("t2_med", got_q[0], 5);
      check("t2_min", got_q[1], 4);
      check("t2_max", got_q[2], 9);
    end

    // 3: backpressure for 5 cycles
    got_q.delete();
    k = 0; held = 0;
    for (int cyc = 0; cyc < 60 && (k < 6 || exp_q.size() != 0); cyc++) begin
      ordy = (held >= 5);
      tick(k < 6, k == 0, 2'b00, 10*k + 3, 10*k + 1, 10*k + 2, ordy, acc);
      if (acc) k++;
      if (last_v && !ordy) begin
        held++;
        check("t3_in_ready_stalled", o_in_ready, 1'b0);
      end
    end
    check("t3_beats_in", k, 6);
    check("t3_held", held, 5);
    check("t3_count", got_q.size(), 4);
    drain();

    // 4: salt-and-pepper line with gaps and random backpressure
    got_q.delete();
    k = 0;
    for (int cyc = 0; cyc < 600 && k < 64; cyc++) begin
      tick($urandom_range(3) != 0, k == 0, 2'b00,
           $urandom_range(1) ? 255 : 0, $urandom_range(1) ? 255 : 0,
           $urandom_range(1) ? 255 : 0, $urandom_range(3) != 0, acc);
      if (acc) k++;
    end
    check("t4_beats_in", k, 64);
    drain();
    check("t4_count", got_q.size(), 62);

    // 5: sol again on the second beat of a line
    got_q.delete();
    push_beat(1'b1, 2'b00, 200, 210, 220);
    push_beat(1'b1, 2'b00, 10, 20, 30);
    push_beat(1'b0, 2'b00, 40, 50, 60);
    idle(4);
    check("t5_no_output", got_q.size(), 0);
    push_beat(1'b0, 2'b00, 70, 80, 90);
    push_beat(1'b0, 2'b00, 95, 96, 97);
    drain();
    check("t5_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t5_first", got_q[0], 50);
      check("t5_second", got_q[1], 80);
    end

    // 6: async reset with a held result
    got_q.delete();
    tick(1'b1, 1'b1, 2'b00, 11, 12, 13, 1'b0, acc);
    tick(1'b1, 1'b0, 2'b00, 14, 15, 16, 1'b0, acc);
    tick(1'b1, 1'b0, 2'b00, 17, 18, 19, 1'b0, acc);
    for (int n = 0; n < 10 && !last_v; n++) tick(1'b0, 1'b0, 2'b00, 0, 0, 0, 1'b0, acc);
    check("t6_valid_before_rst", last_v, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", o_valid, 1'b0);
    check("t6_rst_valid12", o_valid12, 1'b0);
    check("t6_rst_data", o_data, 8'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_beat(1'b0, 2'b00, 30, 31, 32);
    push_beat(1'b0, 2'b00, 33, 34, 35);
    idle(5);
    check("t6_no_output", got_q.size(), 0);
    push_beat(1'b0, 2'b00, 36, 37, 38);
    drain();
    check("t6_count", got_q.size(), 1);
    if (got_q.size() == 1) check("t6_value", got_q[0], 34);

    check("final_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
